cdb_result_queue: RTL and testbench

- Per-execution-unit writeback queue that sits directly upstream of the CDB arbiter, one instance per source (ALU0, ALU1, BR, LSU).
- Captures completed results (phys tag, value, ROB tag) from the execution unit and presents the oldest one to the arbiter as a src request.
- Holds each result until the arbiter grants it a CDB port, so execution units may complete while CDB ports are oversubscribed.
- Provides back-pressure to the execution unit via in_ready, and a saturating stall counter for performance visibility.

---
 rtl/cdb_result_queue_pkg.sv | 13 +
 rtl/core_pkg.sv | 16 +
 rtl/cdb_result_queue.sv | 126 ++++++++++++
 tb/tb_cdb_result_queue.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_result_queue_pkg.sv
// Defaults and elaboration helpers for the per-source CDB result queue.
// Holds the queue depth and stall-counter width shared by all four instances.
// Contents: CRQ_DEPTH, CRQ_CNT_W, is_pow2().
package cdb_result_queue_pkg;

    localparam int CRQ_DEPTH = 4;
    localparam int CRQ_CNT_W = 16;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/core_pkg.sv
// Core-wide widths and the result record carried on the CDB.
// Shared by every writeback source and by the CDB arbiter.
// Defines: XLEN, LOG2_PREGS, ROB_TAG_W, cdb_result_t.
package core_pkg;

    localparam int XLEN       = 32;
    localparam int LOG2_PREGS = 7;
    localparam int ROB_TAG_W  = 6;

    typedef struct packed {
        logic [LOG2_PREGS-1:0] tag;
        logic [XLEN-1:0]       value;
        logic [ROB_TAG_W-1:0]  rob_tag;
    } cdb_result_t;

endpackage

// File: rtl/cdb_result_queue.sv
// Purpose: per-execution-unit FIFO of completed results, oldest presented to the CDB arbiter.
// Latency: 1 cycle from accepted in_valid to out_valid (no bypass), then held until out_grant.
// Backpressure: in_ready = (count < DEPTH) from registered state only; flush drops everything.
//
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   flush                           discard all entries (wins over enqueue/dequeue)
//   in_valid/in_ready, in_tag, in_value, in_rob_tag     result from the execution unit
//   out_valid, out_tag, out_value, out_rob_tag, out_grant  head request to / grant from arbiter
//   occupancy                       number of valid entries
//   stall_cycles                    saturating count of cycles requested but not granted
module cdb_result_queue
    import cdb_result_queue_pkg::*;
#(
    parameter int DEPTH  = CRQ_DEPTH,
    parameter int XLEN   = core_pkg::XLEN,
    parameter int PHYS_W = core_pkg::LOG2_PREGS,
    parameter int ROB_W  = core_pkg::ROB_TAG_W,
    parameter int CNT_W  = CRQ_CNT_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PHYS_W-1:0]          in_tag,
    input  logic [XLEN-1:0]            in_value,
    input  logic [ROB_W-1:0]           in_rob_tag,
    output logic                       out_valid,
    output logic [PHYS_W-1:0]          out_tag,
    output logic [XLEN-1:0]            out_value,
    output logic [ROB_W-1:0]           out_rob_tag,
    input  logic                       out_grant,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           stall_cycles
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    generate
        if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
            $error("cdb_result_queue: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    // Same layout as core_pkg::cdb_result_t, but sized from this instance's parameters.
    typedef struct packed {
        logic [PHYS_W-1:0] tag;
        logic [XLEN-1:0]   value;
        logic [ROB_W-1:0]  rob_tag;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [OCC_W-1:0]   count;
    logic               push;
    logic               pop;

    assign in_ready  = (count < OCC_W'(DEPTH));
    assign out_valid = (count != '0);
    assign occupancy = count;

    // Flush squashes both sides of the handshake for this cycle.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_grant && !flush;

    always_comb begin
        out_tag     = '0;
        out_value   = '0;
        out_rob_tag = '0;
        if (out_valid) begin
            out_tag     = mem[head].tag;
            out_value   = mem[head].value;
            out_rob_tag = mem[head].rob_tag;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Payload storage needs no reset: it is only observed while count != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{tag: in_tag, value: in_value, rob_tag: in_rob_tag};
        end
    end

    // Stall history survives flush so it reflects total arbitration pressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_grant && !flush && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

`ifndef SYNTHESIS
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset_n)
        !(in_valid && in_ready && (count == OCC_W'(DEPTH))));

    a_count_bound: assert property (@(posedge clk) disable iff (!reset_n)
        count <= OCC_W'(DEPTH));

    a_grant_when_empty: assert property (@(posedge clk) disable iff (!reset_n)
        !(out_grant && !out_valid))
        else $warning("cdb_result_queue: out_grant while empty (ignored)");
`endif

endmodule

// File: tb/tb_cdb_result_queue.sv
// Bench for cdb_result_queue: directed stimulus pushes expected results into a
// scoreboard queue; a negedge monitor pops and compares on every dequeue.
module tb_cdb_result_queue;
    import core_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int OCC_W = $clog2(DEPTH+1);

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  flush = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [LOG2_PREGS-1:0] in_tag = '0;
    logic [XLEN-1:0]       in_value = '0;
    logic [ROB_TAG_W-1:0]  in_rob_tag = '0;
    logic                  out_valid;
    logic [LOG2_PREGS-1:0] out_tag;
    logic [XLEN-1:0]       out_value;
    logic [ROB_TAG_W-1:0]  out_rob_tag;
    logic                  out_grant = 1'b0;
    logic [OCC_W-1:0]      occupancy;
    logic [CNT_W-1:0]      stall_cycles;

    int asserts  = 0;
    int failures = 0;

    cdb_result_t exp_q[$];
    cdb_result_t mon_e;

    cdb_result_queue #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN),
        .PHYS_W(LOG2_PREGS),
        .ROB_W (ROB_TAG_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_tag      (in_tag),
        .in_value    (in_value),
        .in_rob_tag  (in_rob_tag),
        .out_valid   (out_valid),
        .out_tag     (out_tag),
        .out_value   (out_value),
        .out_rob_tag (out_rob_tag),
        .out_grant   (out_grant),
        .occupancy   (occupancy),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int tag, input logic [31:0] val, input int rob);
        in_valid   = 1'b1;
        in_tag     = LOG2_PREGS'(tag);
        in_value   = val;
        in_rob_tag = ROB_TAG_W'(rob);
    endtask

    task automatic expect_result(input int tag, input logic [31:0] val, input int rob);
        cdb_result_t e;
        e.tag     = LOG2_PREGS'(tag);
        e.value   = val;
        e.rob_tag = ROB_TAG_W'(rob);
        exp_q.push_back(e);
    endtask

    // Monitor: a dequeue happens at the next posedge whenever valid && grant && !flush.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_grant && !flush) begin
            asserts++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected: got tag=%0d value=%0h rob=%0d, expected no output",
                         out_tag, out_value, out_rob_tag);
            end else begin
                mon_e = exp_q.pop_front();
                if ({out_tag, out_value, out_rob_tag} !== mon_e) begin
                    failures++;
                    $display("FAIL pop_data: got tag=%0d value=%0h rob=%0d, expected tag=%0d value=%0h rob=%0d",
                             out_tag, out_value, out_rob_tag, mon_e.tag, mon_e.value, mon_e.rob_tag);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int   guard;
        logic acc;
        logic gbit;

        // Reset then idle
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_stall",     64'(stall_cycles), 64'd0);
        check("rst_out_tag",   64'(out_tag),   64'd0);
        check("rst_out_value", 64'(out_value), 64'd0);

        // Grant while empty is ignored
        out_grant = 1'b1;
        tick();
        out_grant = 1'b0;
        check("empty_grant_occ", 64'(occupancy), 64'd0);
        check("empty_grant_stall", 64'(stall_cycles), 64'd0);

        // Single result, no bypass
        drive(5, 32'hDEADBEEF, 12);
        expect_result(5, 32'hDEADBEEF, 12);
        check("no_bypass", 64'(out_valid), 64'd0);
        tick();
        in_valid  = 1'b0;
        out_grant = 1'b1;
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_tag",   64'(out_tag),   64'd5);
        check("single_value", 64'(out_value), 64'hDEADBEEF);
        check("single_rob",   64'(out_rob_tag), 64'd12);
        tick();
        out_grant = 1'b0;
        check("single_drained_occ", 64'(occupancy), 64'd0);
        check("single_drained_vld", 64'(out_valid), 64'd0);
        check("single_stall", 64'(stall_cycles), 64'd0);

        // Fill and back-pressure
        for (int t = 1; t <= 4; t++) begin
            drive(t, 32'h100 + 32'(t), 20 + t);
            expect_result(t, 32'h100 + 32'(t), 20 + t);
            tick();
        end
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_occ",      64'(occupancy), 64'd4);
        check("full_stall",    64'(stall_cycles), 64'd3);
        drive(9, 32'h999, 9);           // must not be accepted
        tick();
        check("full_reject_occ", 64'(occupancy), 64'd4);
        check("full_stall2",     64'(stall_cycles), 64'd4);

        // Full with simultaneous grant: only the dequeue happens
        drive(6, 32'h106, 26);
        out_grant = 1'b1;
        check("full_grant_in_ready", 64'(in_ready), 64'd0);
        tick();
        out_grant = 1'b0;
        check("full_grant_occ", 64'(occupancy), 64'd3);
        check("full_grant_in_ready_after", 64'(in_ready), 64'd1);
        check("full_grant_stall", 64'(stall_cycles), 64'd4);
        expect_result(6, 32'h106, 26);
        tick();
        in_valid = 1'b0;
        check("refill_occ",  64'(occupancy), 64'd4);
        check("refill_stall", 64'(stall_cycles), 64'd5);
        out_grant = 1'b1;
        repeat (4) tick();
        out_grant = 1'b0;
        check("full_drained_occ", 64'(occupancy), 64'd0);
        check("full_drained_stall", 64'(stall_cycles), 64'd5);

        // Wrap-around: 10 results, grant toggling every cycle
        gbit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(10 + i, 32'hA000_0000 + 32'(i), 40 + i);
            expect_result(10 + i, 32'hA000_0000 + 32'(i), 40 + i);
            guard = 0;
            do begin
                out_grant = gbit;
                gbit = ~gbit;
                acc = in_ready;
                tick();
                guard++;
            end while (!acc && guard < 10);
            check("wrap_accept", 64'(acc), 64'd1);
        end
        in_valid = 1'b0;
        guard = 0;
        while (occupancy != '0 && guard < 20) begin
            out_grant = 1'b1;
            tick();
            guard++;
        end
        out_grant = 1'b0;
        check("wrap_drained", 64'(occupancy), 64'd0);
        check("wrap_all_out", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset in mid-operation discards entries at once
        drive(40, 32'h40, 1);
        tick();
        drive(41, 32'h41, 2);
        tick();
        in_valid = 1'b0;
        check("pre_reset_occ", 64'(occupancy), 64'd2);
        reset_n = 1'b0;
        #1;
        check("async_rst_occ",   64'(occupancy), 64'd0);
        check("async_rst_vld",   64'(out_valid), 64'd0);
        check("async_rst_stall", 64'(stall_cycles), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Flush collision
        for (int t = 30; t <= 32; t++) begin
            drive(t, 32'h3000 + 32'(t), t - 20);
            tick();
        end
        check("pre_flush_occ",   64'(occupancy), 64'd3);
        check("pre_flush_stall", 64'(stall_cycles), 64'd2);
        drive(33, 32'h3033, 13);
        out_grant = 1'b1;
        flush     = 1'b1;
        exp_q.delete();
        tick();
        flush     = 1'b0;
        out_grant = 1'b0;
        in_valid  = 1'b0;
        check("flush_occ",   64'(occupancy), 64'd0);
        check("flush_vld",   64'(out_valid), 64'd0);
        check("flush_stall", 64'(stall_cycles), 64'd2);
        drive(7, 32'h7777, 7);
        expect_result(7, 32'h7777, 7);
        tick();
        in_valid  = 1'b0;
        out_grant = 1'b1;
        check("post_flush_occ", 64'(occupancy), 64'd1);
        check("post_flush_tag", 64'(out_tag), 64'd7);
        tick();
        out_grant = 1'b0;
        check("post_flush_drained", 64'(occupancy), 64'd0);
        check("post_flush_stall", 64'(stall_cycles), 64'd2);

        tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
